store_station_scheduler: RTL and testbench

Controller for a pool of `NUM_RS` store reservation stations in the Tomasulo back end. It allocates a free station to each issuing store, with round-robin search. It tracks which stations are reserved, and arbitrates completed stations (address and store value resolved) round-robin onto the single registered write-buffer port, using a valid/ready handshake. It sits between the issue stage, the store reservation stations and the write buffer, and obeys ROB flush.

---
 rtl/store_station_scheduler_pkg.sv | 19 +
 rtl/store_station_scheduler_round_robin_picker.sv | 34 +++
 rtl/store_station_scheduler.sv | 143 ++++++++++++++
 tb/tb_store_station_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_station_scheduler_pkg.sv
// Shared widths and helpers for the store reservation station scheduler.
// ROB_POSITION_WIDTH is the default ROB index width and must match the
// REORDER_BUFFER_SIZE_LOG value of the surrounding back end.
package store_station_scheduler_pkg;

  localparam int ROB_POSITION_WIDTH = 4;
  localparam int DATA_WIDTH         = 32;

  // Population count of a vector of up to 32 station flags.
  function automatic int unsigned count_ones(input logic [31:0] bits);
    int unsigned total;
    total = 0;
    for (int i = 0; i < 32; i++) begin
      if (bits[i]) total++;
    end
    return total;
  endfunction

endpackage

// File: rtl/store_station_scheduler_round_robin_picker.sv
// Round-robin picker: finds the first set request at or after the pointer,
// wrapping around. N must be a power of two so the index wraps naturally.
module round_robin_picker #(
  parameter int N     = 4,
  parameter int N_LOG = 2
) (
  input  logic [N-1:0]     request,
  input  logic [N_LOG-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [N_LOG-1:0] index,
  output logic             any
);

  logic [N_LOG-1:0] pos;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = pointer + N_LOG'(k);
      if (!any && request[pos]) begin
        any   = 1'b1;
        index = pos;
        grant = N'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/store_station_scheduler.sv
// Store reservation station scheduler: allocates free stations to issuing
// stores and drains completed stations round-robin into one registered
// write-buffer slot with a valid/ready handshake. Flush discards everything
// except the stale payload bits, which are masked by the cleared valid.
module store_station_scheduler
  import store_station_scheduler_pkg::*;
#(
  parameter int NUM_RS                  = 4,
  parameter int NUM_RS_LOG              = 2,
  parameter int REORDER_BUFFER_SIZE_LOG = ROB_POSITION_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      issue_valid,
  output logic                                      issue_ready,
  output logic [NUM_RS-1:0]                         issue_select,
  input  logic [NUM_RS-1:0]                         rs_busy,
  input  logic [NUM_RS-1:0]                         rs_done,
  input  logic [NUM_RS*REORDER_BUFFER_SIZE_LOG-1:0] rs_position,
  input  logic [NUM_RS*DATA_WIDTH-1:0]              rs_value,
  input  logic [NUM_RS*DATA_WIDTH-1:0]              rs_storeValue,
  output logic [NUM_RS-1:0]                         rs_ack,
  output logic [NUM_RS_LOG:0]                       occupancy,
  output logic                                      writeBuffer_valid,
  input  logic                                      writeBuffer_ready,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0]        writeBuffer_position,
  output logic [DATA_WIDTH-1:0]                     writeBuffer_value,
  output logic [DATA_WIDTH-1:0]                     writeBuffer_storeValue
);

  localparam int OCC_W = NUM_RS_LOG + 1;

  logic [NUM_RS-1:0]     reserved;
  logic [NUM_RS_LOG-1:0] issue_ptr;
  logic [NUM_RS_LOG-1:0] grant_ptr;

  logic [NUM_RS-1:0]     free_set;
  logic [NUM_RS-1:0]     eligible;
  logic [NUM_RS-1:0]     issue_onehot;
  logic [NUM_RS_LOG-1:0] issue_idx;
  logic                  issue_any;
  logic [NUM_RS-1:0]     grant_onehot;
  logic [NUM_RS_LOG-1:0] grant_idx;
  logic                  grant_any;

  logic                  load_ok;
  logic                  issue_fire;
  logic                  grant_fire;

  logic [REORDER_BUFFER_SIZE_LOG-1:0] pick_position;
  logic [DATA_WIDTH-1:0]              pick_value;
  logic [DATA_WIDTH-1:0]              pick_store_value;

  // Candidate sets for the two pickers.
  always_comb begin
    free_set = ~reserved & ~rs_busy;
    eligible = rs_done & reserved;
  end

  round_robin_picker #(
    .N     (NUM_RS),
    .N_LOG (NUM_RS_LOG)
  ) u_issue_picker (
    .request (free_set),
    .pointer (issue_ptr),
    .grant   (issue_onehot),
    .index   (issue_idx),
    .any     (issue_any)
  );

  round_robin_picker #(
    .N     (NUM_RS),
    .N_LOG (NUM_RS_LOG)
  ) u_grant_picker (
    .request (eligible),
    .pointer (grant_ptr),
    .grant   (grant_onehot),
    .index   (grant_idx),
    .any     (grant_any)
  );

  // Handshake-facing outputs, all forced low while resetting or flushing.
  always_comb begin
    load_ok      = !writeBuffer_valid || writeBuffer_ready;
    issue_ready  = !reset && !flush && issue_any;
    issue_select = issue_ready ? issue_onehot : '0;
    issue_fire   = issue_valid && issue_ready;
    grant_fire   = !reset && !flush && load_ok && grant_any;
    rs_ack       = grant_fire ? grant_onehot : '0;
    occupancy    = reset ? '0 : OCC_W'(count_ones(32'(reserved)));
  end

  // Payload of the station the grant picker currently points at.
  always_comb begin
    pick_position    = rs_position[int'(grant_idx)*REORDER_BUFFER_SIZE_LOG +: REORDER_BUFFER_SIZE_LOG];
    pick_value       = rs_value[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    pick_store_value = rs_storeValue[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Reservation bookkeeping and round-robin pointers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || flush) begin
      reserved  <= '0;
      issue_ptr <= '0;
      grant_ptr <= '0;
    end else begin
      // Issue only targets unreserved stations and grants only reserved
      // ones, so the set and clear masks never overlap.
      reserved <= (reserved | (issue_fire ? issue_onehot : '0)) & ~rs_ack;
      if (issue_fire) issue_ptr <= issue_idx + 1'b1;
      if (grant_fire) grant_ptr <= grant_idx + 1'b1;
    end
  end

  // Write-buffer output register: load on grant, drop on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeBuffer_valid      <= 1'b0;
      writeBuffer_position   <= '0;
      writeBuffer_value      <= '0;
      writeBuffer_storeValue <= '0;
    end else if (flush) begin
      writeBuffer_valid <= 1'b0;
    end else if (grant_fire) begin
      writeBuffer_valid      <= 1'b1;
      writeBuffer_position   <= pick_position;
      writeBuffer_value      <= pick_value;
      writeBuffer_storeValue <= pick_store_value;
    end else if (writeBuffer_ready) begin
      writeBuffer_valid <= 1'b0;
    end
  end

  // Grants and allocations are one-hot and never target the same station.
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(rs_ack));
  a_sel_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(issue_select));
  a_no_overlap : assert property (@(posedge clk) disable iff (reset)
                                  (issue_fire ? (issue_onehot & rs_ack) : '0) == '0);

endmodule

// File: tb/tb_store_station_scheduler.sv
// Self-checking bench for store_station_scheduler: directed scenarios plus a
// randomized run against a behavioural reference model of the pool.
module tb_store_station_scheduler;
  import store_station_scheduler_pkg::*;

  localparam int NRS  = 4;
  localparam int NLOG = 2;
  localparam int RL   = ROB_POSITION_WIDTH;

  logic              clk = 1'b0;
  logic              reset, flush, issue_valid, issue_ready;
  logic [NRS-1:0]    issue_select, rs_busy, rs_done, rs_ack;
  logic [NRS*RL-1:0] rs_position;
  logic [NRS*32-1:0] rs_value, rs_storeValue;
  logic [NLOG:0]     occupancy;
  logic              writeBuffer_valid, writeBuffer_ready;
  logic [RL-1:0]     writeBuffer_position;
  logic [31:0]       writeBuffer_value, writeBuffer_storeValue;

  logic [RL-1:0] st_pos [NRS];
  logic [31:0]   st_val [NRS];
  logic [31:0]   st_sv  [NRS];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NRS; g++) begin : g_pack
    assign rs_position[g*RL +: RL]   = st_pos[g];
    assign rs_value[g*32 +: 32]      = st_val[g];
    assign rs_storeValue[g*32 +: 32] = st_sv[g];
  end

  store_station_scheduler #(
    .NUM_RS                  (NRS),
    .NUM_RS_LOG              (NLOG),
    .REORDER_BUFFER_SIZE_LOG (RL)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .flush                  (flush),
    .issue_valid            (issue_valid),
    .issue_ready            (issue_ready),
    .issue_select           (issue_select),
    .rs_busy                (rs_busy),
    .rs_done                (rs_done),
    .rs_position            (rs_position),
    .rs_value               (rs_value),
    .rs_storeValue          (rs_storeValue),
    .rs_ack                 (rs_ack),
    .occupancy              (occupancy),
    .writeBuffer_valid      (writeBuffer_valid),
    .writeBuffer_ready      (writeBuffer_ready),
    .writeBuffer_position   (writeBuffer_position),
    .writeBuffer_value      (writeBuffer_value),
    .writeBuffer_storeValue (writeBuffer_storeValue)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset             = 1'b0;
    flush             = 1'b0;
    issue_valid       = 1'b0;
    rs_busy           = '0;
    rs_done           = '0;
    writeBuffer_ready = 1'b0;
  endtask

  task automatic load_station_data();
    for (int i = 0; i < NRS; i++) begin
      st_pos[i] = RL'(i + 8);
      st_val[i] = 32'h1000 + 32'(i);
      st_sv[i]  = 32'hA000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    load_station_data();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Emulates the stations: a selected station turns busy after the edge.
  task automatic fill4();
    logic [NRS-1:0] sel;
    for (int i = 0; i < NRS; i++) begin
      issue_valid = 1'b1;
      settle();
      sel = issue_select;
      tick();
      rs_busy = rs_busy | sel;
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    load_station_data();
    reset = 1'b1; issue_valid = 1'b1; rs_done = '1; writeBuffer_ready = 1'b1;
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_issue_ready got=%b exp=0", issue_ready); end
    total++; if (issue_select !== 4'b0000) begin bad++; $display("FAIL reset_issue_select got=%b exp=0000", issue_select); end
    total++; if (rs_ack !== 4'b0000) begin bad++; $display("FAIL reset_rs_ack got=%b exp=0000", rs_ack); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    tick();
    settle();
    total++; if (writeBuffer_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", writeBuffer_valid); end
    total++; if ({writeBuffer_position, writeBuffer_value, writeBuffer_storeValue} !== '0) begin
      bad++; $display("FAIL reset_wb_data got=%h/%h/%h exp=0", writeBuffer_position, writeBuffer_value, writeBuffer_storeValue);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_issue_fill();
    logic [NRS-1:0] exp_sel;
    do_reset();
    for (int i = 0; i < NRS; i++) begin
      issue_valid = 1'b1;
      exp_sel = 4'(1 << i);
      settle();
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, issue_ready); end
      total++; if (issue_select !== exp_sel) begin bad++; $display("FAIL fill_select[%0d] got=%b exp=%b", i, issue_select, exp_sel); end
      total++; if (occupancy !== 3'(i)) begin bad++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, occupancy, i); end
      tick();
      rs_busy[i] = 1'b1;
    end
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", issue_ready); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    issue_valid = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    fill4();
    st_pos[2] = RL'(3); st_val[2] = 32'd12; st_sv[2] = 32'd5;
    rs_done = 4'b0100;
    settle();
    total++; if (rs_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", rs_ack); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL single_ready_same_cycle got=%b exp=0", issue_ready); end
    tick();
    rs_busy[2] = 1'b0; rs_done = '0;
    settle();
    total++; if (writeBuffer_valid !== 1'b1) begin bad++; $display("FAIL single_wb_valid got=%b exp=1", writeBuffer_valid); end
    total++; if (writeBuffer_position !== RL'(3)) begin bad++; $display("FAIL single_wb_pos got=%0d exp=3", writeBuffer_position); end
    total++; if (writeBuffer_value !== 32'd12) begin bad++; $display("FAIL single_wb_value got=%0d exp=12", writeBuffer_value); end
    total++; if (writeBuffer_storeValue !== 32'd5) begin bad++; $display("FAIL single_wb_sv got=%0d exp=5", writeBuffer_storeValue); end
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL single_occ got=%0d exp=3", occupancy); end
    total++; if (issue_select !== 4'b0100) begin bad++; $display("FAIL single_reissue_sel got=%b exp=0100", issue_select); end
    writeBuffer_ready = 1'b1;
    tick();
    settle();
    total++; if (writeBuffer_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", writeBuffer_valid); end
    writeBuffer_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NRS-1:0] exp_ack;
    do_reset();
    fill4();
    rs_done = 4'b1111; writeBuffer_ready = 1'b1;
    for (int i = 0; i < NRS; i++) begin
      exp_ack = 4'(1 << i);
      settle();
      total++; if (rs_ack !== exp_ack) begin bad++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, rs_ack, exp_ack); end
      if (i > 0) begin
        total++; if (writeBuffer_value !== st_val[i-1] || writeBuffer_position !== st_pos[i-1] || writeBuffer_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_wb[%0d] got=%b/%h/%h exp=1/%h/%h", i, writeBuffer_valid, writeBuffer_position, writeBuffer_value, st_pos[i-1], st_val[i-1]);
        end
      end
      tick();
      rs_busy[i] = 1'b0; rs_done[i] = 1'b0;
    end
    settle();
    total++; if (writeBuffer_storeValue !== st_sv[3] || writeBuffer_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_last got=%b/%h exp=1/%h", writeBuffer_valid, writeBuffer_storeValue, st_sv[3]);
    end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL b2b_occ got=%0d exp=0", occupancy); end
    tick();
    writeBuffer_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    fill4();
    rs_done = 4'b1111; writeBuffer_ready = 1'b0;
    settle();
    total++; if (rs_ack !== 4'b0001) begin bad++; $display("FAIL bp_first_ack got=%b exp=0001", rs_ack); end
    tick();
    rs_busy[0] = 1'b0; rs_done[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++; if (rs_ack !== 4'b0000) begin bad++; $display("FAIL bp_hold_ack[%0d] got=%b exp=0000", k, rs_ack); end
      total++; if (writeBuffer_valid !== 1'b1 || writeBuffer_value !== st_val[0] || writeBuffer_position !== st_pos[0]) begin
        bad++; $display("FAIL bp_hold_wb[%0d] got=%b/%h/%h exp=1/%h/%h", k, writeBuffer_valid, writeBuffer_position, writeBuffer_value, st_pos[0], st_val[0]);
      end
      tick();
    end
    writeBuffer_ready = 1'b1;
    settle();
    total++; if (rs_ack !== 4'b0010) begin bad++; $display("FAIL bp_release_ack got=%b exp=0010", rs_ack); end
    tick();
    rs_busy[1] = 1'b0; rs_done[1] = 1'b0; writeBuffer_ready = 1'b0;
    settle();
    total++; if (writeBuffer_value !== st_val[1] || writeBuffer_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release_wb got=%b/%h exp=1/%h", writeBuffer_valid, writeBuffer_value, st_val[1]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill4();
    rs_done = 4'b0001; writeBuffer_ready = 1'b0;
    tick();
    rs_busy[0] = 1'b0; rs_done = '0;
    issue_valid = 1'b1;
    settle();
    total++; if (issue_select !== 4'b0001) begin bad++; $display("FAIL flush_refill_sel got=%b exp=0001", issue_select); end
    tick();
    rs_busy[0] = 1'b1; issue_valid = 1'b0;
    rs_done = 4'b0010; writeBuffer_ready = 1'b1;
    settle();
    total++; if (rs_ack !== 4'b0010) begin bad++; $display("FAIL flush_pre_ack got=%b exp=0010", rs_ack); end
    tick();
    rs_busy[1] = 1'b0; rs_done = '0; writeBuffer_ready = 1'b0;
    settle();
    total++; if (occupancy !== 3'd3 || writeBuffer_valid !== 1'b1 || writeBuffer_position !== st_pos[1]) begin
      bad++; $display("FAIL flush_pre_state got=%0d/%b/%h exp=3/1/%h", occupancy, writeBuffer_valid, writeBuffer_position, st_pos[1]);
    end
    tick();
    flush = 1'b1; issue_valid = 1'b1; rs_done = 4'b0100;
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_issue_ready got=%b exp=0", issue_ready); end
    total++; if (rs_ack !== 4'b0000) begin bad++; $display("FAIL flush_rs_ack got=%b exp=0000", rs_ack); end
    tick();
    flush = 1'b0; rs_busy = '0; rs_done = '0;
    settle();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (writeBuffer_valid !== 1'b0) begin bad++; $display("FAIL flush_wb_valid got=%b exp=0", writeBuffer_valid); end
    total++; if (issue_select !== 4'b0001) begin bad++; $display("FAIL flush_next_sel got=%b exp=0001", issue_select); end
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic test_full_issue_grant();
    do_reset();
    fill4();
    issue_valid = 1'b1; rs_done = 4'b0100;
    settle();
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL fig_ready got=%b exp=0", issue_ready); end
    total++; if (rs_ack !== 4'b0100) begin bad++; $display("FAIL fig_ack got=%b exp=0100", rs_ack); end
    tick();
    rs_busy[2] = 1'b0; rs_done = '0;
    settle();
    total++; if (issue_ready !== 1'b1 || issue_select !== 4'b0100) begin
      bad++; $display("FAIL fig_next got=%b/%b exp=1/0100", issue_ready, issue_select);
    end
    tick();
    rs_busy[2] = 1'b1; issue_valid = 1'b0;
    settle();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fig_occ got=%0d exp=4", occupancy); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    fill4();
    rs_done = 4'b0001; writeBuffer_ready = 1'b0;
    tick();
    rs_busy[0] = 1'b0; rs_done = '0;
    settle();
    total++; if (writeBuffer_valid !== 1'b1) begin bad++; $display("FAIL midreset_pre got=%b exp=1", writeBuffer_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0; rs_busy = '0;
    settle();
    total++; if (writeBuffer_valid !== 1'b0 || writeBuffer_value !== 32'd0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL midreset_post got=%b/%h/%0d exp=0/0/0", writeBuffer_valid, writeBuffer_value, occupancy);
    end
  endtask

  // First set bit of m at or after position p, wrapping; -1 when m is empty.
  function automatic int first_from(input logic [NRS-1:0] m, input int p);
    for (int k = 0; k < NRS; k++) begin
      int j;
      j = (p + k) % NRS;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic test_random();
    logic [NRS-1:0] m_res, free_m, elig_m, e_sel, e_ack;
    int             m_iptr, m_gptr, ii, gi;
    logic           m_wbv, e_rdy;
    logic [RL-1:0]  m_pos;
    logic [31:0]    m_val, m_sv;
    int             e_occ;
    do_reset();
    m_res = '0; m_iptr = 0; m_gptr = 0; m_wbv = 1'b0; m_pos = '0; m_val = '0; m_sv = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset             = ($urandom_range(0, 63) == 0);
      flush             = ($urandom_range(0, 31) == 0);
      issue_valid       = ($urandom_range(0, 2) != 0);
      rs_busy           = m_res | (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      rs_done           = 4'($urandom);
      writeBuffer_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NRS; i++) begin
        st_pos[i] = RL'($urandom);
        st_val[i] = $urandom;
        st_sv[i]  = $urandom;
      end
      free_m = ~m_res & ~rs_busy;
      elig_m = rs_done & m_res;
      ii     = first_from(free_m, m_iptr);
      gi     = first_from(elig_m, m_gptr);
      e_rdy  = !reset && !flush && (ii >= 0);
      e_sel  = e_rdy ? 4'(1 << ii) : 4'b0000;
      e_ack  = (!reset && !flush && (!m_wbv || writeBuffer_ready) && gi >= 0) ? 4'(1 << gi) : 4'b0000;
      e_occ  = reset ? 0 : $countones(m_res);
      settle();
      total++; if (issue_ready !== e_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, e_rdy); end
      total++; if (issue_select !== e_sel) begin bad++; $display("FAIL rand_select cyc=%0d got=%b exp=%b", cyc, issue_select, e_sel); end
      total++; if (rs_ack !== e_ack) begin bad++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, rs_ack, e_ack); end
      total++; if (occupancy !== 3'(e_occ)) begin bad++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, e_occ); end
      total++; if (writeBuffer_valid !== m_wbv || writeBuffer_position !== m_pos || writeBuffer_value !== m_val || writeBuffer_storeValue !== m_sv) begin
        bad++; $display("FAIL rand_wb cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", cyc, writeBuffer_valid, writeBuffer_position,
                        writeBuffer_value, writeBuffer_storeValue, m_wbv, m_pos, m_val, m_sv);
      end
      if (reset) begin
        m_res = '0; m_iptr = 0; m_gptr = 0; m_wbv = 1'b0; m_pos = '0; m_val = '0; m_sv = '0;
      end else if (flush) begin
        m_res = '0; m_iptr = 0; m_gptr = 0; m_wbv = 1'b0;
      end else begin
        if (issue_valid && ii >= 0) begin
          m_res[ii] = 1'b1;
          m_iptr    = (ii + 1) % NRS;
        end
        if (e_ack != 4'b0000) begin
          m_res[gi] = 1'b0;
          m_gptr    = (gi + 1) % NRS;
          m_wbv     = 1'b1;
          m_pos     = st_pos[gi];
          m_val     = st_val[gi];
          m_sv      = st_sv[gi];
        end else if (writeBuffer_ready) begin
          m_wbv = 1'b0;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    load_station_data();
    #1;
    test_reset();
    test_issue_fill();
    test_single_grant();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_full_issue_grant();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
